note_step_sequencer: RTL and testbench

- Schedules the square-wave tone generator that feeds the PmodDA2 audio path.
- Holds a 32-step pattern of 4-bit tone codes (4 pages x 8 steps) and advances one step per tempo period.
- Per step, outputs the tone generator's half-period count, a mute flag, a one-hot step indicator for LEDs/display, and a note-start strobe.
- Provides play/pause/stop control, optional looping, and a pattern write port for the page editor.

---
 rtl/note_step_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_note_step_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_step_sequencer.sv
// Step sequencer for the square-wave tone path: 32-slot pattern, one step per tempo period.
// Step loads appear on the outputs one edge after the triggering condition; no backpressure.
module note_step_sequencer #(
  parameter int STEPS     = 32,
  parameter int HP_W      = 26,
  parameter int MIN_TICKS = 2
) (
  input  logic              clock,
  input  logic              RST_N,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [31:0]       step_ticks,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [3:0]        wr_data,
  output logic [4:0]        step_idx,
  output logic [STEPS-1:0]  step_onehot,
  output logic [3:0]        tone_code,
  output logic [HP_W-1:0]   half_period,
  output logic              mute,
  output logic              note_start,
  output logic              pattern_done,
  output logic              playing
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2
  } state_e;

  localparam logic [4:0]       LAST_IDX   = 5'(STEPS - 1);
  localparam logic [STEPS-1:0] ONEHOT_TOP = {1'b1, {(STEPS-1){1'b0}}};

  state_e           state_q, state_d;
  logic [4:0]       step_q, step_d;
  logic [STEPS-1:0] onehot_q, onehot_d;
  logic [3:0]       tone_q, tone_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             mute_q, mute_d;
  logic             note_start_q, note_start_d;
  logic             done_q, done_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      ticks_q, ticks_d;
  logic [3:0]       pat_q [STEPS];

  logic             load_en;
  logic [4:0]       load_idx;
  logic [3:0]       load_code;
  logic             idle_en;
  logic [31:0]      eff_ticks;

  // Codes 8..15 are rests: no toggling threshold.
  function automatic logic [HP_W-1:0] hp_lookup(input logic [3:0] code);
    case (code)
      4'd0:    hp_lookup = HP_W'(305810);
      4'd1:    hp_lookup = HP_W'(272479);
      4'd2:    hp_lookup = HP_W'(242718);
      4'd3:    hp_lookup = HP_W'(229042);
      4'd4:    hp_lookup = HP_W'(204081);
      4'd5:    hp_lookup = HP_W'(181818);
      4'd6:    hp_lookup = HP_W'(161969);
      4'd7:    hp_lookup = HP_W'(152905);
      default: hp_lookup = '0;
    endcase
  endfunction

  assign eff_ticks = (step_ticks < 32'(MIN_TICKS)) ? 32'(MIN_TICKS) : step_ticks;
  assign load_code = pat_q[load_idx];

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    onehot_d     = onehot_q;
    tone_d       = tone_q;
    hp_d         = hp_q;
    mute_d       = mute_q;
    cnt_d        = cnt_q;
    ticks_d      = ticks_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;
    load_en      = 1'b0;
    load_idx     = 5'd0;
    idle_en      = 1'b0;

    if (stop) begin
      idle_en = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            load_en = 1'b1;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (play) begin
            state_d = S_PAUSED;
            mute_d  = 1'b1;
          end else if (cnt_q == ticks_q - 32'd1) begin
            if (step_q != LAST_IDX) begin
              load_en  = 1'b1;
              load_idx = step_q + 5'd1;
            end else if (loop_en) begin
              load_en = 1'b1;
            end else begin
              idle_en = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_PAUSED: begin
          if (play) begin
            state_d = S_PLAY;
            mute_d  = tone_q[3];
          end
        end
        default: idle_en = 1'b1;
      endcase
    end

    // Load reads the pattern before any same-cycle write lands.
    if (load_en) begin
      step_d       = load_idx;
      onehot_d     = ONEHOT_TOP >> load_idx;
      tone_d       = load_code;
      hp_d         = hp_lookup(load_code);
      mute_d       = load_code[3];
      note_start_d = 1'b1;
      cnt_d        = '0;
      ticks_d      = eff_ticks;
    end

    if (idle_en) begin
      state_d  = S_IDLE;
      step_d   = 5'd0;
      onehot_d = ONEHOT_TOP;
      tone_d   = 4'hF;
      hp_d     = '0;
      mute_d   = 1'b1;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      step_q       <= 5'd0;
      onehot_q     <= ONEHOT_TOP;
      tone_q       <= 4'hF;
      hp_q         <= '0;
      mute_q       <= 1'b1;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      ticks_q      <= 32'(MIN_TICKS);
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      onehot_q     <= onehot_d;
      tone_q       <= tone_d;
      hp_q         <= hp_d;
      mute_q       <= mute_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      ticks_q      <= ticks_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!RST_N) begin
      for (int i = 0; i < STEPS; i++) pat_q[i] <= 4'hF;
    end else if (wr_en) begin
      pat_q[wr_addr] <= wr_data;
    end
  end

  assign step_idx     = step_q;
  assign step_onehot  = onehot_q;
  assign tone_code    = tone_q;
  assign half_period  = hp_q;
  assign mute         = mute_q;
  assign note_start   = note_start_q;
  assign pattern_done = done_q;
  assign playing      = (state_q == S_PLAY);

endmodule

// File: tb/tb_note_step_sequencer.sv
// Bench for note_step_sequencer: tone-table vectors, directed corner sequences, random run vs model.
module tb_note_step_sequencer;

  logic        clock = 1'b0;
  logic        RST_N, play, stop, loop_en, wr_en;
  logic [31:0] step_ticks;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [4:0]  step_idx;
  logic [31:0] step_onehot;
  logic [3:0]  tone_code;
  logic [25:0] half_period;
  logic        mute, note_start, pattern_done, playing;

  note_step_sequencer dut (
    .clock(clock), .RST_N(RST_N), .play(play), .stop(stop), .loop_en(loop_en),
    .step_ticks(step_ticks), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_idx(step_idx), .step_onehot(step_onehot), .tone_code(tone_code),
    .half_period(half_period), .mute(mute), .note_start(note_start),
    .pattern_done(pattern_done), .playing(playing)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode plus cycles left in the current step.
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;
  int          m_mode;
  int          m_step;
  int unsigned m_left;
  logic [3:0]  m_pat [32];
  logic [3:0]  m_tone;
  int unsigned m_hp;
  bit          m_mute, m_ns, m_done;

  function automatic int unsigned tone_hp(input logic [3:0] c);
    int unsigned tbl [8] = '{305810, 272479, 242718, 229042, 204081, 181818, 161969, 152905};
    return (c < 8) ? tbl[c] : 0;
  endfunction

  task automatic m_load(input int s);
    m_step = s;
    m_tone = m_pat[s];
    m_hp   = tone_hp(m_tone);
    m_mute = (m_tone > 7);
    m_ns   = 1;
    m_left = (step_ticks < 2) ? 2 : step_ticks;
  endtask

  task automatic m_idle();
    m_mode = M_IDLE; m_step = 0; m_tone = 4'hF; m_hp = 0; m_mute = 1;
  endtask

  task automatic model_update();
    m_ns = 0; m_done = 0;
    if (!RST_N) begin
      m_idle();
      for (int i = 0; i < 32; i++) m_pat[i] = 4'hF;
      return;
    end
    if (stop) m_idle();
    else if (m_mode == M_IDLE) begin
      if (play) begin m_load(0); m_mode = M_PLAY; end
    end else if (m_mode == M_PLAY) begin
      if (play) begin m_mode = M_PAUSE; m_mute = 1; end
      else if (m_left == 1) begin
        if (m_step < 31) m_load(m_step + 1);
        else if (loop_en) m_load(0);
        else begin m_idle(); m_done = 1; end
      end else m_left--;
    end else if (play) begin
      m_mode = M_PLAY; m_mute = (m_tone > 7);
    end
    if (wr_en) m_pat[wr_addr] = wr_data;
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    @(negedge clock);
    check("step_idx",     32'(step_idx),     32'(m_step));
    check("step_onehot",  step_onehot,       32'd1 << (31 - m_step));
    check("tone_code",    32'(tone_code),    32'(m_tone));
    check("half_period",  32'(half_period),  m_hp);
    check("mute",         32'(mute),         32'(m_mute));
    check("note_start",   32'(note_start),   32'(m_ns));
    check("pattern_done", 32'(pattern_done), 32'(m_done));
    check("playing",      32'(playing),      32'(m_mode == M_PLAY));
    play = 0; stop = 0; wr_en = 0;
  endtask

  task automatic write_slot(input int a, input int d);
    wr_en = 1; wr_addr = 5'(a); wr_data = 4'(d); tick();
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [25:0] hp;
    logic        mute;
  } vec_t;
  vec_t vecs [16];

  int ns_cnt;
  int muted_loads;

  initial begin
    vecs[0] = '{4'd0, 26'd305810, 1'b0};
    vecs[1] = '{4'd1, 26'd272479, 1'b0};
    vecs[2] = '{4'd2, 26'd242718, 1'b0};
    vecs[3] = '{4'd3, 26'd229042, 1'b0};
    vecs[4] = '{4'd4, 26'd204081, 1'b0};
    vecs[5] = '{4'd5, 26'd181818, 1'b0};
    vecs[6] = '{4'd6, 26'd161969, 1'b0};
    vecs[7] = '{4'd7, 26'd152905, 1'b0};
    for (int i = 8; i < 16; i++) vecs[i] = '{4'(i), 26'd0, 1'b1};

    RST_N = 0; play = 0; stop = 0; loop_en = 0; wr_en = 0;
    step_ticks = 4; wr_addr = 0; wr_data = 0;
    tick(); tick();
    check("reset_onehot", step_onehot, 32'h8000_0000);
    check("reset_tone",   32'(tone_code), 32'hF);
    check("reset_mute",   32'(mute), 32'd1);
    RST_N = 1;
    tick();

    // Basic pass: slots 0..3 = 1,7,3,9, T=4
    write_slot(0, 1); write_slot(1, 7); write_slot(2, 3); write_slot(3, 9);
    play = 1; tick();
    check("t1_hp0", 32'(half_period), 272479);
    check("t1_ns0", 32'(note_start), 1);
    for (int i = 0; i < 3; i++) tick();
    check("t1_ns_gap", 32'(note_start), 0);
    tick();
    check("t1_hp1", 32'(half_period), 152905);
    check("t1_oh1", step_onehot, 32'h4000_0000);
    for (int i = 0; i < 4; i++) tick();
    check("t1_hp2", 32'(half_period), 229042);
    for (int i = 0; i < 4; i++) tick();
    check("t1_hp3", 32'(half_period), 0);
    check("t1_mute3", 32'(mute), 1);
    check("t1_ns3", 32'(note_start), 1);
    stop = 1; tick();

    // Tone table vectors
    step_ticks = 100;
    for (int v = 0; v < 16; v++) begin
      write_slot(0, vecs[v].code);
      play = 1; tick();
      check("vec_hp",   32'(half_period), 32'(vecs[v].hp));
      check("vec_mute", 32'(mute), 32'(vecs[v].mute));
      check("vec_ns",   32'(note_start), 1);
      stop = 1; tick();
    end

    // Full pattern, non-looping then looping, T=2
    step_ticks = 2; loop_en = 0;
    play = 1; tick();
    for (int i = 0; i < 64; i++) tick();
    check("full_done", 32'(pattern_done), 1);
    check("full_playing", 32'(playing), 0);
    check("full_step", 32'(step_idx), 0);
    check("full_mute", 32'(mute), 1);
    check("full_ns", 32'(note_start), 0);
    loop_en = 1;
    play = 1; tick();
    for (int i = 0; i < 64; i++) tick();
    check("loop_ns", 32'(note_start), 1);
    check("loop_done", 32'(pattern_done), 0);
    check("loop_playing", 32'(playing), 1);
    stop = 1; tick();

    // Pause/resume with T=10
    step_ticks = 10; loop_en = 0;
    play = 1; tick();
    for (int i = 0; i < 20; i++) tick();
    check("pz_step2", 32'(step_idx), 2);
    for (int i = 0; i < 3; i++) tick();
    play = 1; tick();
    ns_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (note_start) ns_cnt++;
    end
    check("pz_hold_step", 32'(step_idx), 2);
    check("pz_hold_mute", 32'(mute), 1);
    check("pz_hold_ns", 32'(ns_cnt), 0);
    play = 1; tick();
    check("pz_resume_ns", 32'(note_start), 0);
    ns_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (note_start) ns_cnt++;
    end
    check("pz_early_ns", 32'(ns_cnt), 0);
    tick();
    check("pz_step3_ns", 32'(note_start), 1);
    check("pz_step3", 32'(step_idx), 3);

    // stop + play together while playing
    tick();
    stop = 1; play = 1; tick();
    check("sp_playing", 32'(playing), 0);
    check("sp_step", 32'(step_idx), 0);

    // Same-cycle write to the slot being loaded
    step_ticks = 2; loop_en = 1;
    write_slot(5, 4);
    play = 1; tick();
    for (int i = 0; i < 9; i++) tick();
    wr_en = 1; wr_addr = 5; wr_data = 0; tick();
    check("rbw_step", 32'(step_idx), 5);
    check("rbw_hp_old", 32'(half_period), 204081);
    for (int i = 0; i < 64; i++) tick();
    check("rbw_step_next", 32'(step_idx), 5);
    check("rbw_hp_new", 32'(half_period), 305810);
    stop = 1; tick();

    // step_ticks 0 and 1 behave as 2
    step_ticks = 0;
    play = 1; tick();
    tick();
    check("t0_mid", 32'(note_start), 0);
    step_ticks = 1;
    tick();
    check("t0_ns", 32'(note_start), 1);
    tick(); tick();
    check("t1_ns", 32'(note_start), 1);
    check("t1_step", 32'(step_idx), 2);
    stop = 1; tick();

    // step_ticks 4 -> 8 mid-step
    step_ticks = 4;
    play = 1; tick();
    tick(); tick();
    step_ticks = 8;
    tick(); tick();
    check("chg_ns4", 32'(note_start), 1);
    ns_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (note_start) ns_cnt++;
    end
    check("chg_gap", 32'(ns_cnt), 0);
    tick();
    check("chg_ns8", 32'(note_start), 1);

    // Reset mid-play, then replay: every slot is a rest
    tick(); tick();
    RST_N = 0; tick();
    check("rst_step", 32'(step_idx), 0);
    check("rst_onehot", step_onehot, 32'h8000_0000);
    check("rst_tone", 32'(tone_code), 32'hF);
    check("rst_hp", 32'(half_period), 0);
    check("rst_mute", 32'(mute), 1);
    check("rst_playing", 32'(playing), 0);
    RST_N = 1; step_ticks = 2; loop_en = 0;
    play = 1; tick();
    muted_loads = 0;
    for (int i = 0; i < 32; i++) begin
      if (note_start && mute && half_period == 0) muted_loads++;
      tick(); tick();
    end
    check("rst_replay_muted", 32'(muted_loads), 32);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      play    = ($urandom_range(0, 15) == 0);
      stop    = ($urandom_range(0, 63) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom);
      wr_data = 4'($urandom);
      if ($urandom_range(0, 7) == 0) step_ticks = $urandom_range(0, 5);
      if ($urandom_range(0, 31) == 0) loop_en = 1'($urandom);
      RST_N = ($urandom_range(0, 999) != 0);
      tick();
    end
    RST_N = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
